mbinit_repairclk_rx: RTL

MBINIT_REPAIRCLK_RX -- requirements
Module: mbinit_repairclk_rx

---
 rtl/ltsm_mbinit_pkg.sv | 34 +++
 rtl/repairclk_lane_det.sv | 38 +++
 rtl/mbinit_repairclk_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ltsm_mbinit_pkg.sv
// Shared MBINIT REPAIRCLK definitions: sideband message codes and step state encoding.
// Used by both the RX and TX sides of the handshake.
package ltsm_mbinit_pkg;

    localparam int unsigned MSG_NONE        = 0;
    localparam int unsigned MSG_INIT_REQ    = 1;
    localparam int unsigned MSG_INIT_RESP   = 2;
    localparam int unsigned MSG_RESULT_REQ  = 3;
    localparam int unsigned MSG_RESULT_RESP = 4;
    localparam int unsigned MSG_DONE_REQ    = 5;
    localparam int unsigned MSG_DONE_RESP   = 6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT_REQ,
        SEND_INIT_RESP,
        DETECT,
        SEND_RESULT_RESP,
        WAIT_DONE_REQ,
        SEND_DONE_RESP,
        RX_END
    } repairclk_state_e;

    // Response code driven while sitting in a SEND_* state; MSG_NONE elsewhere.
    function automatic int unsigned resp_code(repairclk_state_e s);
        case (s)
            SEND_INIT_RESP:   return MSG_INIT_RESP;
            SEND_RESULT_RESP: return MSG_RESULT_RESP;
            SEND_DONE_RESP:   return MSG_DONE_RESP;
            default:          return MSG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/repairclk_lane_det.sv
// Per-lane clock-pattern detect counter: saturating count of detect pulses,
// pass when the count reaches DET_THRESHOLD.
module repairclk_lane_det #(
    parameter int unsigned DET_THRESHOLD = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear_i,
    input  logic enable_i,
    input  logic pulse_i,
    output logic pass_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && pulse_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pass is taken from the registered count, so a pulse in the sampling cycle is not included.
    assign pass_o = (cnt_q >= CNT_W'(DET_THRESHOLD));

endmodule

// File: rtl/mbinit_repairclk_rx.sv
// MBINIT REPAIRCLK receiver: answers the partner's init/result/done requests and
// logs per-lane clock-pattern detection. Optional step timeout under REPAIRCLK_RX_TIMEOUT_EN.
module mbinit_repairclk_rx
    import ltsm_mbinit_pkg::*;
#(
    parameter int unsigned SB_MSG_Width   = 4,
    parameter int unsigned DET_THRESHOLD  = 16,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_mbinit_repairclk_en,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
    input  logic                    i_sb_valid,
    input  logic                    i_rckp_det,
    input  logic                    i_rckn_det,
    input  logic                    i_rtrk_det,
    output logic [SB_MSG_Width-1:0] o_encoded_sb_msg,
    output logic                    o_msg_valid,
    output logic                    o_det_en,
    output logic [2:0]              o_logged_results,
    output logic                    o_rx_end,
    output logic                    o_timeout
);

    localparam logic [SB_MSG_Width-1:0] C_INIT_REQ   = SB_MSG_Width'(MSG_INIT_REQ);
    localparam logic [SB_MSG_Width-1:0] C_RESULT_REQ = SB_MSG_Width'(MSG_RESULT_REQ);
    localparam logic [SB_MSG_Width-1:0] C_DONE_REQ   = SB_MSG_Width'(MSG_DONE_REQ);

    repairclk_state_e        state_q, state_d;
    logic [SB_MSG_Width-1:0] pend_q, pend_d;
    logic [SB_MSG_Width-1:0] rx_msg;
    logic                    has_msg;
    logic                    clear_cnt;
    logic                    latch_res;
    logic                    tmo_hit;
    logic [2:0]              lane_pass;
    logic [2:0]              res_q, res_d;
    logic [SB_MSG_Width-1:0] code_q;
    logic                    msg_valid_q, det_en_q, rx_end_q;

    // A request that arrives while our TX is busy is parked in pend_q until busy drops.
    assign has_msg = i_sb_valid || (pend_q != '0);
    assign rx_msg  = i_sb_valid ? i_decoded_sb_msg : pend_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        latch_res = 1'b0;
        case (state_q)
            IDLE: state_d = WAIT_INIT_REQ;
            WAIT_INIT_REQ: begin
                if (has_msg && rx_msg == C_INIT_REQ) begin
                    if (!i_sb_busy) state_d = SEND_INIT_RESP;
                    else            pend_d  = C_INIT_REQ;
                end
            end
            SEND_INIT_RESP:   if (i_falling_edge_busy) state_d = DETECT;
            DETECT: begin
                if (has_msg && rx_msg == C_INIT_REQ) begin
                    if (!i_sb_busy) state_d = SEND_INIT_RESP;
                    else            pend_d  = C_INIT_REQ;
                end else if (has_msg && rx_msg == C_RESULT_REQ) begin
                    latch_res = i_sb_valid;
                    if (!i_sb_busy) state_d = SEND_RESULT_RESP;
                    else            pend_d  = C_RESULT_REQ;
                end
            end
            SEND_RESULT_RESP: if (i_falling_edge_busy) state_d = WAIT_DONE_REQ;
            WAIT_DONE_REQ: begin
                if (has_msg && rx_msg == C_DONE_REQ) begin
                    if (!i_sb_busy) state_d = SEND_DONE_RESP;
                    else            pend_d  = C_DONE_REQ;
                end
            end
            SEND_DONE_RESP:   if (i_falling_edge_busy) state_d = RX_END;
            RX_END:           state_d = RX_END;
            default:          state_d = IDLE;
        endcase
        if (tmo_hit)                state_d = IDLE;
        if (!i_mbinit_repairclk_en) state_d = IDLE;
        if (state_d != state_q)     pend_d  = '0;
    end

    assign clear_cnt = (state_q == IDLE) ||
                       ((state_d == SEND_INIT_RESP) && (state_q != SEND_INIT_RESP));

    always_comb begin
        res_d = res_q;
        if (state_d == IDLE) res_d = '0;
        else if (latch_res)  res_d = lane_pass;
    end

    // NOTE: the asynchronous reset clears state and every output register at once, so a
    // send request in flight drops without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            res_q       <= '0;
            code_q      <= '0;
            msg_valid_q <= 1'b0;
            det_en_q    <= 1'b0;
            rx_end_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            res_q       <= res_d;
            code_q      <= SB_MSG_Width'(resp_code(state_d));
            msg_valid_q <= (resp_code(state_d) != MSG_NONE);
            det_en_q    <= (state_d == DETECT);
            rx_end_q    <= (state_d == RX_END);
        end
    end

`ifdef REPAIRCLK_RX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_active;
    logic             timeout_q;

    assign tmo_active = (state_q != IDLE) && (state_q != RX_END);
    assign tmo_hit    = tmo_active && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (!tmo_active || (state_d != state_q)) tmo_cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_hit;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
    assign tmo_hit        = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    repairclk_lane_det #(.DET_THRESHOLD(DET_THRESHOLD), .CNT_W(CNT_W)) u_rckp_det (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .clear_i(clear_cnt), .enable_i(det_en_q),
        .pulse_i(i_rckp_det), .pass_o(lane_pass[0])
    );

    repairclk_lane_det #(.DET_THRESHOLD(DET_THRESHOLD), .CNT_W(CNT_W)) u_rckn_det (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .clear_i(clear_cnt), .enable_i(det_en_q),
        .pulse_i(i_rckn_det), .pass_o(lane_pass[1])
    );

    repairclk_lane_det #(.DET_THRESHOLD(DET_THRESHOLD), .CNT_W(CNT_W)) u_rtrk_det (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .clear_i(clear_cnt), .enable_i(det_en_q),
        .pulse_i(i_rtrk_det), .pass_o(lane_pass[2])
    );

    assign o_encoded_sb_msg = code_q;
    assign o_msg_valid      = msg_valid_q;
    assign o_det_en         = det_en_q;
    assign o_rx_end         = rx_end_q;
    assign o_logged_results = res_q;

endmodule
